// File: rtl/burst_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_pkg
// Purpose  : Shared command encoding, FSM state encoding and sizing helper
//            for the burst RAM responder.
// Revision : 1.0 - initial release
// ============================================================================
package burst_ram_pkg;

    // Command encoding on the br_ cmd line
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Responder state encoding; INIT is reachable only in the power-up build
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        READ_DATA = 3'd3,
        INIT      = 3'd4
    } state_t;

    // Bits needed for a counter that must be able to hold max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_responder_if
// Purpose  : br_ command/data bundle between the RAM/cache controller
//            (master) and the burst RAM responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface burst_ram_responder_if #(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DATA_BITWIDTH  = 64
);
    logic                         cmd;
    logic                         cmd_en;
    logic [DEPTH_BITWIDTH-1:0]    addr;
    logic [DATA_BITWIDTH-1:0]     wr_data;
    logic [DATA_BITWIDTH/8-1:0]   data_mask;
    logic [DATA_BITWIDTH-1:0]     rd_data;
    logic                         rd_data_valid;
    logic                         busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/burst_ram_mem.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_mem
// Purpose  : Single-port word array with per-byte write enables and a
//            registered, enable-gated read port (block RAM style).
//            The read register clears on reset; the array itself never does.
// Revision : 1.0 - initial release
// ============================================================================
module burst_ram_mem #(
    parameter int ADDR_BITWIDTH = 8,
    parameter int DATA_BITWIDTH = 64
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic [ADDR_BITWIDTH-1:0]   i_addr,
    input  wire logic [DATA_BITWIDTH/8-1:0] i_byte_we,
    input  wire logic [DATA_BITWIDTH-1:0]   i_wr_data,
    input  wire logic                       i_rd_en,
    output logic      [DATA_BITWIDTH-1:0]   o_rd_data
);
    localparam int c_BYTES = DATA_BITWIDTH / 8;
    localparam int c_WORDS = 1 << ADDR_BITWIDTH;

    logic [DATA_BITWIDTH-1:0] r_mem [0:c_WORDS-1];
    logic [DATA_BITWIDTH-1:0] r_rd_data;

    // Byte-granular write; unselected bytes keep their previous contents
    always_ff @(posedge clk) begin
        for (int b = 0; b < c_BYTES; b++) begin
            if (i_byte_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
            end
        end
    end

    // Registered read; holds the last word whenever no read is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/burst_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_responder
// Purpose  : Burst RAM responder on the br_ interface. Accepts read/write
//            bursts of BURST_COUNT beats, writes with per-byte masks, and
//            returns read bursts READ_LATENCY cycles after accept.
//            Optional macro BURST_RAM_POWERUP_DELAY_EN adds an INIT period of
//            INIT_CYCLES busy cycles after reset (external RAM calibration).
// Revision : 1.0 - initial release
// ============================================================================
module burst_ram_responder
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4,
    parameter int READ_LATENCY   = 2,
    parameter int INIT_CYCLES    = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    burst_ram_responder_if.slave  br
);
    localparam int c_BYTES  = DATA_BITWIDTH / 8;
    localparam int c_BEAT_W = $clog2(BURST_COUNT);
    // One counter times both the read latency and the power-up period
    localparam int c_CNT_MAX = (READ_LATENCY > INIT_CYCLES) ? READ_LATENCY : INIT_CYCLES;
    localparam int c_CNT_W   = cnt_width(c_CNT_MAX);

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_COUNT - 1);
    localparam logic [c_CNT_W-1:0]  c_LAT_LAST  = c_CNT_W'(READ_LATENCY - 1);

    state_t                    r_state;
    logic [c_BEAT_W-1:0]       r_beat;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [DEPTH_BITWIDTH-1:0] r_addr;   // array address of the next beat
    logic                      r_busy;
    logic                      r_rd_valid;

    logic                      w_accept;
    logic [DEPTH_BITWIDTH-1:0] w_mem_addr;
    logic [c_BYTES-1:0]        w_mem_we;
    logic                      w_mem_re;
    logic [DATA_BITWIDTH-1:0]  w_mem_q;

    // Memory port steering: a read is issued one cycle before its beat is
    // presented, so the array's registered output lines up with rd_data_valid
    always_comb begin
        w_accept   = br.cmd_en & ~r_busy & ~rst;
        w_mem_addr = r_addr;
        w_mem_we   = '0;
        w_mem_re   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mem_addr = br.addr;
                    if (br.cmd == CMD_WRITE) begin
                        w_mem_we = ~br.data_mask;
                    end else begin
                        w_mem_re = (READ_LATENCY == 1);
                    end
                end
            end
            WRITE: begin
                if (!rst) begin
                    w_mem_we = ~br.data_mask;
                end
            end
            READ_WAIT: w_mem_re = (r_cnt == c_LAT_LAST);
            READ_DATA: w_mem_re = (r_beat != c_LAST_BEAT);
            default: ;
        endcase
    end

    // Command FSM with beat/latency counters, address walk and output flags
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef BURST_RAM_POWERUP_DELAY_EN
            r_state <= INIT;
            r_busy  <= 1'b1;
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
`endif
            r_beat     <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_mem_re;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (br.cmd == CMD_WRITE) begin
                            r_state <= WRITE;
                            r_beat  <= c_BEAT_W'(1);
                            r_addr  <= br.addr + 1'b1;
                        end else if (READ_LATENCY == 1) begin
                            r_state <= READ_DATA;
                            r_beat  <= '0;
                            r_addr  <= br.addr + 1'b1;
                        end else begin
                            r_state <= READ_WAIT;
                            r_cnt   <= c_CNT_W'(1);
                            r_addr  <= br.addr;
                        end
                    end
                end
                WRITE: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_beat == c_LAST_BEAT) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (w_mem_re) begin
                        r_state <= READ_DATA;
                        r_beat  <= '0;
                        r_addr  <= r_addr + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READ_DATA: begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                        r_addr <= r_addr + 1'b1;
                    end
                end
`ifdef BURST_RAM_POWERUP_DELAY_EN
                INIT: begin
                    if (r_cnt == c_CNT_W'(INIT_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    burst_ram_mem #(
        .ADDR_BITWIDTH (DEPTH_BITWIDTH),
        .DATA_BITWIDTH (DATA_BITWIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (w_mem_addr),
        .i_byte_we (w_mem_we),
        .i_wr_data (br.wr_data),
        .i_rd_en   (w_mem_re),
        .o_rd_data (w_mem_q)
    );

    assign br.rd_data       = w_mem_q;
    assign br.rd_data_valid = r_rd_valid;
    assign br.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_burst_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_ram_responder
// Purpose  : Self-checking bench for burst_ram_responder: table of bursts
//            against a byte-level memory model, plus hand sequences for
//            masking, wrap, dropped commands, back-to-back and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_ram_responder;
    import burst_ram_pkg::*;

    localparam int AW       = 8;
    localparam int DW       = 64;
    localparam int BL       = 4;
    localparam int LAT      = 2;
    localparam int INIT_CYC = 16;
    localparam int NV       = 13;

    typedef logic [BL-1:0][DW-1:0]  beats_t;
    typedef logic [BL-1:0][DW/8-1:0] masks_t;

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        beats_t        data;
        masks_t        mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    burst_ram_responder_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) br ();

    burst_ram_responder #(
        .DEPTH_BITWIDTH (AW),
        .DATA_BITWIDTH  (DW),
        .BURST_COUNT    (BL),
        .READ_LATENCY   (LAT),
        .INIT_CYCLES    (INIT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .br  (br)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [0:(1<<AW)-1];
    vec_t          tbl   [NV];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic beats_t beats4(input logic [DW-1:0] b0, b1, b2, b3);
        beats_t r;
        r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
        return r;
    endfunction

    function automatic masks_t masks4(input logic [7:0] m0, m1, m2, m3);
        masks_t r;
        r[0] = m0; r[1] = m1; r[2] = m2; r[3] = m3;
        return r;
    endfunction

    function automatic beats_t model_beats(input logic [AW-1:0] a);
        beats_t        r;
        logic [AW-1:0] wa;
        for (int i = 0; i < BL; i++) begin
            wa   = a + AW'(i);
            r[i] = model[wa];
        end
        return r;
    endfunction

    // Every valid beat must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (br.rd_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got rd_data=%h with valid, expected no beat", br.rd_data);
            end else begin
                check("rd_beat", br.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset(input int ncyc);
        rst       = 1'b1;
        br.cmd_en = 1'b0;
        repeat (ncyc) tick;
        rst = 1'b0;
        check("rst_valid", br.rd_data_valid, 0);
        check("rst_rd_data", br.rd_data, 0);
`ifdef BURST_RAM_POWERUP_DELAY_EN
        for (int k = 0; k < INIT_CYC; k++) begin
            check("init_busy", br.busy, 1);
            br.cmd_en = 1'b1;
            br.cmd    = CMD_READ;
            br.addr   = 8'h10;
            tick;
        end
        br.cmd_en = 1'b0;
        check("init_done_busy", br.busy, 0);
`else
        check("rst_busy", br.busy, 0);
`endif
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input beats_t d, input masks_t m);
        logic [AW-1:0] wa;
        check("wr_accept_busy", br.busy, 0);
        br.cmd_en = 1'b1;
        br.cmd    = CMD_WRITE;
        br.addr   = a;
        for (int i = 0; i < BL; i++) begin
            if (i > 0) check("wr_busy", br.busy, 1);
            br.wr_data   = d[i];
            br.data_mask = m[i];
            wa = a + AW'(i);
            for (int b = 0; b < DW/8; b++) begin
                if (!m[i][b]) model[wa][b*8 +: 8] = d[i][b*8 +: 8];
            end
            tick;
            br.cmd_en = 1'b0;
        end
    endtask

    // drop=1 offers a write to 0x20 in every busy cycle; it must be ignored
    task automatic issue_read(input logic [AW-1:0] a, input beats_t e, input logic drop);
        check("rd_accept_busy", br.busy, 0);
        br.cmd_en = 1'b1;
        br.cmd    = CMD_READ;
        br.addr   = a;
        for (int i = 0; i < BL; i++) exp_q.push_back(e[i]);
        tick;
        for (int k = 1; k <= LAT + BL; k++) begin
            if (drop && k < LAT + BL) begin
                br.cmd_en    = 1'b1;
                br.cmd       = CMD_WRITE;
                br.addr      = 8'h20;
                br.wr_data   = '0;
                br.data_mask = '0;
            end else begin
                br.cmd_en = 1'b0;
            end
            check("rd_valid_timing", br.rd_data_valid, (k >= LAT && k < LAT + BL));
            check("rd_busy_timing", br.busy, (k < LAT + BL));
            if (k < LAT + BL) tick;
        end
    endtask

    initial begin
        br.cmd       = CMD_READ;
        br.cmd_en    = 1'b0;
        br.addr      = '0;
        br.wr_data   = '0;
        br.data_mask = '0;

        tbl[0]  = '{1'b1, 8'h20, beats4(64'h5A5A_5A5A_5A5A_5A01, 64'h5A5A_5A5A_5A5A_5A02,
                                        64'h5A5A_5A5A_5A5A_5A03, 64'h5A5A_5A5A_5A5A_5A04), masks4(0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 8'h10, beats4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                        64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444), masks4(0, 0, 0, 0)};
        tbl[2]  = '{1'b0, 8'h10, '0, '0};
        tbl[3]  = '{1'b1, 8'h30, beats4({DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}), masks4(0, 0, 0, 0)};
        tbl[4]  = '{1'b1, 8'h30, beats4(0, 0, 0, 0), masks4(8'h0F, 8'hF0, 8'hFF, 8'h00)};
        tbl[5]  = '{1'b0, 8'h30, '0, '0};
        tbl[6]  = '{1'b1, 8'hFE, beats4(64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                                        64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3), masks4(0, 0, 0, 0)};
        tbl[7]  = '{1'b1, 8'h02, beats4(64'hB2B2_B2B2_B2B2_B2B2, 64'hB3B3_B3B3_B3B3_B3B3,
                                        64'hB4B4_B4B4_B4B4_B4B4, 64'hB5B5_B5B5_B5B5_B5B5), masks4(0, 0, 0, 0)};
        tbl[8]  = '{1'b0, 8'h00, '0, '0};
        tbl[9]  = '{1'b0, 8'hFE, '0, '0};
        tbl[10] = '{1'b1, 8'h10, beats4(64'hC0C0_C0C0_C0C0_C0C0, 64'hC1C1_C1C1_C1C1_C1C1,
                                        64'hC2C2_C2C2_C2C2_C2C2, 64'hC3C3_C3C3_C3C3_C3C3), masks4(8'hAA, 8'h55, 8'h81, 8'h7E)};
        tbl[11] = '{1'b0, 8'h10, '0, '0};
        tbl[12] = '{1'b0, 8'h20, '0, '0};

        do_reset(2);

        // Table bursts, issued back to back (read-after-write included)
        for (int v = 0; v < NV; v++) begin
            if (tbl[v].is_wr) issue_write(tbl[v].addr, tbl[v].data, tbl[v].mask);
            else              issue_read(tbl[v].addr, model_beats(tbl[v].addr), 1'b0);
        end

        // Masked write result, spelled out
        issue_read(8'h30, beats4(64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000), 1'b0);
        // Wrap-around burst, spelled out
        issue_read(8'hFE, beats4(64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                                 64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3), 1'b0);

        // Writes offered while a read is in flight are dropped; 0x20 unchanged
        issue_read(8'h10, model_beats(8'h10), 1'b1);
        issue_read(8'h20, beats4(64'h5A5A_5A5A_5A5A_5A01, 64'h5A5A_5A5A_5A5A_5A02,
                                 64'h5A5A_5A5A_5A5A_5A03, 64'h5A5A_5A5A_5A5A_5A04), 1'b0);

        // Back to back: write then read at cycle 4, read then read at cycle 6
        issue_write(8'h40, beats4(64'hD0, 64'hD1, 64'hD2, 64'hD3), masks4(0, 0, 0, 0));
        issue_read(8'h40, beats4(64'hD0, 64'hD1, 64'hD2, 64'hD3), 1'b0);
        issue_read(8'h40, beats4(64'hD0, 64'hD1, 64'hD2, 64'hD3), 1'b0);

        // Reset during beat 1 of a read: only beats 0 and 1 appear
        check("mid_rst_accept_busy", br.busy, 0);
        br.cmd_en = 1'b1;
        br.cmd    = CMD_READ;
        br.addr   = 8'h10;
        exp_q.push_back(model[8'h10]);
        exp_q.push_back(model[8'h11]);
        tick;
        br.cmd_en = 1'b0;
        tick;
        tick;
        do_reset(1);
        issue_read(8'h10, model_beats(8'h10), 1'b0);

        repeat (4) tick;
        check("queue_drained", DW'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_ram_responder.md
# burst_ram_responder

Single-clock responder for the burst RAM command interface (`br_` wiring) driven by the RAM/cache controller. It accepts read and write burst commands, stores data in an internal byte-maskable array, and returns read bursts after a fixed latency. It serves two roles: a synthesizable on-chip stand-in for the external burst RAM, and the memory model in SoC-level simulation.

## Interface
Parameters:
- `DEPTH_BITWIDTH`, 8, address width; the array holds 2^DEPTH_BITWIDTH words.
- `DATA_BITWIDTH`, 64, width of one beat; must be a multiple of 8.
- `BURST_COUNT`, 4, number of beats per burst; must be a power of 2 and ≥ 2.
- `READ_LATENCY`, 2, number of cycles from command accept to the first valid read beat; must be ≥ 1.
- `INIT_CYCLES`, 16, length of the power-up busy period; used only with `BURST_RAM_POWERUP_DELAY_EN`.

Ports:
- `clk`, input, 1, the clock. Reset is synchronous and active-high.
- `rst`, input, 1, synchronous active-high reset.
- `cmd`, input, 1, command type: 0 = read, 1 = write.
- `cmd_en`, input, 1, command strobe; sampled with `cmd` and `addr`.
- `addr`, input, DEPTH_BITWIDTH, word address of beat 0.
- `wr_data`, input, DATA_BITWIDTH, write beat data.
- `data_mask`, input, DATA_BITWIDTH/8, per-byte mask for the write beat; 1 means the byte is not written.
- `rd_data`, output, DATA_BITWIDTH, read beat data.
- `rd_data_valid`, output, 1, `rd_data` is valid this cycle.
- `busy`, output, 1, when high, commands are ignored.

## Operation
- A command is accepted in a cycle where `cmd_en=1` and `busy=0`. If `cmd_en=1` while `busy=1`, the command is dropped silently and has no effect.
- Beat i of a burst addresses `(addr + i) mod 2^DEPTH_BITWIDTH`; addresses wrap from the top of the array to 0.
- Write burst:
  - Beat 0 `wr_data`/`data_mask` are sampled in the accept cycle.
  - Beats 1..BURST_COUNT-1 are sampled on the following consecutive cycles.
  - Only bytes whose mask bit is 0 are written; masked bytes keep their old value.
- Read burst: `BURST_COUNT` consecutive beats are returned, in order, with `rd_data_valid=1` on each.
- States:
  - IDLE: on accept, go to WRITE if `cmd=1`, else READ_WAIT.
  - WRITE: stay until beat BURST_COUNT-1 has been taken, then go to IDLE.
  - READ_WAIT: count `READ_LATENCY` cycles, then go to READ_DATA.
  - READ_DATA: emit `BURST_COUNT` beats, then go to IDLE.
  - INIT (only with the macro): count `INIT_CYCLES` cycles, then go to IDLE.
- Beat counter width is $clog2(BURST_COUNT). The latency counter is sized to hold `READ_LATENCY`.
- Read-after-write: a read accepted on the first cycle `busy=0` after a write returns the newly written data.
- Reset:
  - Values at reset: `busy=0`, `rd_data_valid=0`, `rd_data=0`.
  - Reset mid-burst aborts the burst and returns to IDLE (or INIT with the macro). Beats already written are kept; array contents are never cleared.

## Timing
- Cycle 0 is the accept cycle.
- Write:
  - Beats are sampled in cycles 0..BURST_COUNT-1.
  - `busy=1` in cycles 1..BURST_COUNT-1.
  - A new command can be accepted in cycle BURST_COUNT.
- Read:
  - `rd_data_valid=1` in cycles READ_LATENCY..READ_LATENCY+BURST_COUNT-1.
  - `busy=1` in cycles 1..READ_LATENCY+BURST_COUNT-1.
  - A new command can be accepted in cycle READ_LATENCY+BURST_COUNT.
- `busy`, `rd_data` and `rd_data_valid` are registered outputs.
- `rd_data` holds its last value when `rd_data_valid=0`.

## Configuration
- `BURST_RAM_POWERUP_DELAY_EN` defined:
  - After reset the block enters INIT and holds `busy=1` for `INIT_CYCLES` cycles. The reset value of `busy` is 1.
  - This models external RAM calibration; the controller waits for `busy=0` before its first access.
- Not defined: no INIT state, `busy=0` from reset, and a command is accepted in the first cycle after reset.

## Structure
- Package `burst_ram_pkg`:
  - command encoding `CMD_READ=1'b0`, `CMD_WRITE=1'b1`;
  - the state encoding constants (IDLE, WRITE, READ_WAIT, READ_DATA, INIT).
- Sub-module `burst_ram_mem`: a single-port array with `DATA_BITWIDTH/8` byte write enables and a registered read. It is inferred as block RAM.
- The top level holds the state machine, the counters, address increment and wrap, and output registers.

## Test plan
- Write, then read: write burst at addr 0x10 with beats 0x11..,0x22..,0x33..,0x44.. and mask 0, then read at 0x10. Expect `rd_data_valid` high in cycles 2..5 after accept, with the same four beats in order.
- Masked write: the word holds 0xFFFF_FFFF_FFFF_FFFF; write 0 with `data_mask=8'h0F`. Read back 0x0000_0000_FFFF_FFFF.
- Wrap-around: write burst at addr 0xFE. Words 0xFE, 0xFF, 0x00, 0x01 are written; a read at 0xFE returns them in that order.
- Busy drop: assert `cmd_en` for a write to 0x20 while a read is in progress. `busy` stays high and 0x20 is unchanged. Back-to-back commands are accepted exactly at cycle 4 (write) or 6 (read).
- Reset mid-read: assert `rst` in the cycle of beat 1. Next cycle `rd_data_valid=0` and `busy=0` (macro off), and memory is unchanged.
- Macro on: after reset, `busy=1` for 16 cycles. `cmd_en` during that time is ignored; the first command is accepted in cycle 16.
